// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, state, alu_op and mux-select encodings for the multicycle control unit
package mips_ctrl_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEX, S_RTWB, S_IEX, S_IWB, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_LUI   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_J};
    endfunction
endpackage

// File: rtl/mips_multicycle_control_outdec.sv
// mips_ctrl_outdec: Moore decode of state into datapath controls; FETCH write enables wait on mem_ready
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op
);
    always_comb begin
        mem_req    = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM2;
                illegal_op = !legal_op(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op(opcode);
            end
            S_IWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = opcode == OP_BNE ? !zero : zero;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: state register and next-state logic of the multicycle MIPS main control
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op
);
    state_t state_q, state_d;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (opcode)
                OP_LW, OP_SW:                      state_d = S_MEMADR;
                OP_R:                              state_d = S_RTEX;
                OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_IEX;
                OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                OP_J:                              state_d = S_JUMP;
                default:                           state_d = S_FETCH;
            endcase
            S_MEMADR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_RTWB;
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q <= !rst_n ? S_START : state_d;
    end

    mips_ctrl_outdec u_outdec (
        .state      (state_q),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .i_or_d     (i_or_d),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op)
    );
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle main control unit for the MIPS core. It sequences one shared ALU, one shared memory port and the register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. Per state it drives the 4-bit `op` bus consumed by ALU_CONTROL, plus datapath mux selects and write enables. It replaces the single-cycle combinational main decoder and sits between the instruction register and the datapath.

## Interface
- No parameters. Opcode, state and alu_op encodings are fixed constants in the shared package.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: IR[31:26], stable from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `i_or_d` out 1: 0 = PC addresses memory, 1 = ALUOut addresses memory.
- `mem_write` out 1: store strobe.
- `ir_write` out 1: load IR.
- `pc_write` out 1: unconditional PC load.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = reg A.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- `alu_op` out 4: to ALU_CONTROL `op`.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = MDR.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- `alu_op` codes: 0000 add, 0001 sub, 0010 R-type (funct-decoded), 0011 and, 0101 or, 0100 lui.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, lui 001111, j 000010.
- States: START, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, IEX, IWB, BRANCH, JUMP.
- Outputs are Moore-decoded from state. Exception: `ir_write` and `pc_write` in FETCH are gated by `mem_ready`.
- Any output not listed for a state is 0 in that state.
- START: all outputs 0. Always goes to FETCH next.
- FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=01, alu_op=0000, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Holds while !mem_ready. Goes to DECODE on mem_ready.
- DECODE: src_a=0, src_b=11, alu_op=0000 (branch target into ALUOut).
  - lw/sw → MEMADR; R → RTEX; addi/andi/ori/lui → IEX; beq/bne → BRANCH; j → JUMP.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEMADR: src_a=1, src_b=10, alu_op=0000. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, i_or_d=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEMWR: mem_req=1, i_or_d=1, mem_write=1. Holds until mem_ready, then FETCH.
- RTEX: src_a=1, src_b=00, alu_op=0010. Then RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- IEX: src_a=1, src_b=10. alu_op per opcode: addi 0000, andi 0011, ori 0101, lui 0100. Then IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=0001, pc_src=01.
  - pc_write = zero for beq, !zero for bne.
  - Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.

## Timing
- rst_n=0 sampled at an edge: state←START. All outputs read 0 during and in the cycle after reset.
- Reset asserted mid-instruction aborts it; no write enable is asserted in the following cycle.
- With zero memory wait, instruction latency in cycles:
  - R-type, addi/andi/ori/lui, sw: 4.
  - lw: 5.
  - beq/bne, j: 3.
  - illegal opcode: 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting, mem_req, i_or_d and mem_write are held stable.
- Memory handshake: the access completes in the cycle where mem_req & mem_ready are both 1. mem_ready while mem_req=0 is ignored.
- At most one of reg_write, mem_write, ir_write is 1 in any cycle.
- pc_write is asserted at most once per instruction outside FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode localparams;
  - state encoding (4-bit, binary);
  - alu_op codes (ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_AND, ALU_OR, ALU_LUI);
  - pc_src and alu_src_b encodings.
- One sub-module, `mips_ctrl_outdec`: pure combinational state+opcode+zero+mem_ready → control outputs.
- The top level holds only the state register and next-state logic.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 → outputs all 0. FETCH is reached one cycle after release.
- add, mem_ready=1: opcode 000000 → FETCH, DECODE, RTEX (alu_op=0010, src_b=00), RTWB (reg_write=1, reg_dst=1), back to FETCH in 4 cycles.
- lw with 2 wait cycles in MEMRD: opcode 100011 → MEMRD lasts 3 cycles with mem_req=1, i_or_d=1. MEMWB then has mem_to_reg=1. Total 7 cycles.
- Branches:
  - beq, zero=1 → BRANCH pc_write=1, pc_src=01, alu_op=0001.
  - beq, zero=0 → pc_write=0.
  - bne, zero=0 → pc_write=1.
- ori/lui: IEX alu_op=0101 for 001101 and 0100 for 001111. IWB reg_dst=0.
- Illegal opcode 111111 → illegal_op=1 for exactly one cycle, no write enable, FETCH next.
- Reset in MEMWR with mem_ready=0 → mem_write drops next cycle, state START.
